issue_window: RTL and testbench
===============================

Name: issue_window

Overview:
Parametrised in-order issue/commit window, the multi-port successor to the single-entry issue path.
- Accepts up to NrIssuePorts decoded instructions per cycle and hands each a transaction ID.
- Issues them in order, up to NrIssuePorts per cycle, to the execute stage.
- Tracks write-back completion and presents up to NrCommitPorts in-order completed entries to commit.
- Sits between id_stage and ex/commit stages; payload is opaque.

Parameters:
NrIssuePorts, 2, decode/issue ports per cycle (1..4)
NrCommitPorts, 2, commit ports per cycle (1..4)
NrWbPorts, 4, write-back ports
NrEntries, 8, window depth; power of two, >= NrIssuePorts
DataWidth, 64, opaque payload bits per entry
TransIdBits, $clog2(NrEntries), derived; not overridable

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
flush_i  in  1  discard entire window
flush_unissued_i  in  1  discard allocated-but-unissued entries
stall_i  in  1  block all issue this cycle
dec_valid_i  in  NrIssuePorts  decode valid per port
dec_data_i  in  NrIssuePorts x DataWidth  decode payload
dec_ack_o  out  NrIssuePorts  decode accepted
issue_valid_o  out  NrIssuePorts  issue valid per port
issue_data_o  out  NrIssuePorts x DataWidth  issued payload
issue_trans_id_o  out  NrIssuePorts x TransIdBits  ID of issued entry
issue_ack_i  in  NrIssuePorts  FU accepted
wb_valid_i  in  NrWbPorts  write-back valid
wb_trans_id_i  in  NrWbPorts x TransIdBits  completing ID
commit_valid_o  out  NrCommitPorts  head entries ready to commit
commit_data_o  out  NrCommitPorts x DataWidth  commit payload
commit_trans_id_o  out  NrCommitPorts x TransIdBits  commit ID
commit_ack_i  in  NrCommitPorts  commit accepted
occupancy_o  out  TransIdBits+1  allocated entries
full_o  out  1  occupancy_o == NrEntries

Behaviour:
Clock and reset:
- Single clock clk_i.
- rst_ni is asynchronous, active-low.
- On reset: all pointers 0, all done/issued bits 0, payload storage 0.
- Outputs after reset: every valid/ack 0, data and ID outputs 0, occupancy_o 0, full_o 0.

Pointers:
- commit_ptr <= issue_ptr <= alloc_ptr, each TransIdBits+1 bits.
- Wrap bit is the MSB; trans ID = low TransIdBits bits.
- total = alloc-commit; unissued = alloc-issue; free = NrEntries-total.
- All three counts are computed from registered state only; there is no same-cycle bypass.

Decode:
- dec_ack_o[i] = dec_valid_i[0..i] all 1 AND free > i AND !flush_i AND !flush_unissued_i.
- Accepted entries are written at alloc_ptr+i. alloc_ptr advances by the popcount of the acked prefix.
- A full window accepts nothing, even if commit frees slots the same cycle.

Issue:
- issue_valid_o[i] = unissued > i AND !stall_i AND !flush_i AND !flush_unissued_i.
- Port i presents entry issue_ptr+i.
- Only the leading run of issue_valid_o & issue_ack_i counts; issue_ptr advances by that run length and sets each entry's issued bit.
- An ack on port i after a gap (port i-1 not acked) is ignored.
- Decode-to-issue latency is 1 cycle minimum.

Write-back:
- Sets done[id] only if the entry is allocated and issued; otherwise the write-back is ignored and flagged by an assertion.
- Multiple ports carrying the same ID in one cycle are legal.
- A write-back in the same cycle as issue of that ID is ignored.

Commit:
- commit_valid_o[j] = total > j AND issued AND done for entry commit_ptr+j AND commit_valid_o[0..j-1] all 1.
- commit_ptr advances by the leading run of commit_valid_o & commit_ack_i, clearing issued/done for those entries.
- A freed slot is reusable from the next cycle.

Flush:
- flush_unissued_i: next cycle alloc_ptr <= issue_ptr. Issued entries are untouched.
- flush_i overrides all other events: next cycle all pointers 0, all bits 0.
- Both flushes suppress decode acks and issue valids in the asserted cycle.
- If both flushes are asserted, flush_i wins.

Decomposition:
- Shared package holds the pointer typedef (TransIdBits+1 bits) and a function returning the leading-ones length of a vector. The function is used by decode, issue and commit.
- One natural sub-module, issue_window_entry_bank:
  - holds the NrEntries payload registers and issued/done bits;
  - has NrIssuePorts write ports, NrIssuePorts + NrCommitPorts read ports and NrWbPorts done-set ports.
- Pointer/count logic stays in the top level.

Test Plan:
1. Reset, then dec_valid_i=2'b11 with payloads A,B -> dec_ack_o=2'b11, trans IDs 0,1. Next cycle issue_valid_o=2'b11, occupancy_o=2.
2. 8 entries allocated, none committed -> full_o=1, dec_ack_o=0. A commit_ack the same cycle still gives no ack; ack returns the following cycle.
3. issue_ack_i=2'b10 with both valid -> nothing issued, issue_ptr unchanged. Then 2'b01 -> only ID 0 issued.
4. IDs 0,1 issued; write-back ID 1 only -> commit_valid_o=0. Add write-back ID 0 -> commit_valid_o=2'b11. Ack both -> occupancy_o drops by 2.
5. Wrap: push/commit 13 entries through the window -> trans IDs cycle 0..7, 0..4. full_o is correct at pointer MSB mismatch.
6. 3 issued + 2 unissued, flush_unissued_i pulse -> occupancy_o=3, the issued entries still commit. Then flush_i pulse -> occupancy_o=0, all valids 0.

Source files
------------

// File: rtl/issue_window_pkg.sv
// Shared types and helpers for the in-order issue/commit window.
package issue_window_pkg;

    localparam int NR_ENTRIES    = 8;
    localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES);
    localparam int MAX_PORTS     = 4;

    // Window pointer: low bits are the trans ID, MSB is the wrap bit.
    typedef logic [TRANS_ID_BITS:0] ptr_t;
    typedef logic [2:0]             port_cnt_t;

    function automatic port_cnt_t lead_ones(input logic [MAX_PORTS-1:0] v);
        port_cnt_t n;
        logic      run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            run = run & v[i];
            n   = n + port_cnt_t'(run);
        end
        return n;
    endfunction

endpackage

// File: rtl/issue_window_entry_bank.sv
// Payload storage plus per-entry issued/done flags for the issue window.
module issue_window_entry_bank #(
    parameter int NrWrPorts  = 2,
    parameter int NrRdPorts  = 4,
    parameter int NrWbPorts  = 4,
    parameter int NrClrPorts = 2,
    parameter int NrEntries  = 8,
    parameter int DataWidth  = 64,
    parameter int IdxBits    = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NrWrPorts-1:0]                 wr_en_i,
    input  logic [NrWrPorts-1:0][IdxBits-1:0]    wr_idx_i,
    input  logic [NrWrPorts-1:0][DataWidth-1:0]  wr_data_i,
    input  logic [NrWrPorts-1:0]                 iss_en_i,
    input  logic [NrWrPorts-1:0][IdxBits-1:0]    iss_idx_i,
    input  logic [NrWbPorts-1:0]                 done_en_i,
    input  logic [NrWbPorts-1:0][IdxBits-1:0]    done_idx_i,
    input  logic [NrClrPorts-1:0]                clr_en_i,
    input  logic [NrClrPorts-1:0][IdxBits-1:0]   clr_idx_i,
    input  logic [NrRdPorts-1:0][IdxBits-1:0]    rd_idx_i,
    output logic [NrRdPorts-1:0][DataWidth-1:0]  rd_data_o,
    output logic [NrEntries-1:0]                 issued_o,
    output logic [NrEntries-1:0]                 done_o
);

    logic [NrEntries-1:0][DataWidth-1:0] payload;
    logic [NrEntries-1:0]                issued, done, issued_n, done_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload <= '0;
        end else begin
            for (int i = 0; i < NrWrPorts; i++)
                if (wr_en_i[i]) payload[wr_idx_i[i]] <= wr_data_i[i];
        end
    end

    // Commit clear is applied last so a late write-back cannot resurrect a freed slot.
    always_comb begin
        issued_n = issued;
        done_n   = done;
        for (int i = 0; i < NrWrPorts; i++)
            if (iss_en_i[i]) issued_n[iss_idx_i[i]] = 1'b1;
        for (int k = 0; k < NrWbPorts; k++)
            if (done_en_i[k]) done_n[done_idx_i[k]] = 1'b1;
        for (int j = 0; j < NrClrPorts; j++)
            if (clr_en_i[j]) begin
                issued_n[clr_idx_i[j]] = 1'b0;
                done_n[clr_idx_i[j]]   = 1'b0;
            end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued <= '0;
            done   <= '0;
        end else if (flush_i) begin
            issued <= '0;
            done   <= '0;
        end else begin
            issued <= issued_n;
            done   <= done_n;
        end
    end

    always_comb begin
        for (int r = 0; r < NrRdPorts; r++) rd_data_o[r] = payload[rd_idx_i[r]];
    end

    assign issued_o = issued;
    assign done_o   = done;

endmodule

// File: rtl/issue_window.sv
// In-order multi-port issue/commit window; pointers and counts live here.
module issue_window
    import issue_window_pkg::*;
#(
    parameter  int NrIssuePorts  = 2,
    parameter  int NrCommitPorts = 2,
    parameter  int NrWbPorts     = 4,
    parameter  int NrEntries     = NR_ENTRIES,
    parameter  int DataWidth     = 64,
    localparam int TransIdBits   = $clog2(NrEntries)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic                                      flush_unissued_i,
    input  logic                                      stall_i,
    input  logic [NrIssuePorts-1:0]                   dec_valid_i,
    input  logic [NrIssuePorts-1:0][DataWidth-1:0]    dec_data_i,
    output logic [NrIssuePorts-1:0]                   dec_ack_o,
    output logic [NrIssuePorts-1:0]                   issue_valid_o,
    output logic [NrIssuePorts-1:0][DataWidth-1:0]    issue_data_o,
    output logic [NrIssuePorts-1:0][TransIdBits-1:0]  issue_trans_id_o,
    input  logic [NrIssuePorts-1:0]                   issue_ack_i,
    input  logic [NrWbPorts-1:0]                      wb_valid_i,
    input  logic [NrWbPorts-1:0][TransIdBits-1:0]     wb_trans_id_i,
    output logic [NrCommitPorts-1:0]                  commit_valid_o,
    output logic [NrCommitPorts-1:0][DataWidth-1:0]   commit_data_o,
    output logic [NrCommitPorts-1:0][TransIdBits-1:0] commit_trans_id_o,
    input  logic [NrCommitPorts-1:0]                  commit_ack_i,
    output logic [TransIdBits:0]                      occupancy_o,
    output logic                                      full_o
);

    localparam int NrRdPorts = NrIssuePorts + NrCommitPorts;

    ptr_t alloc_ptr, issue_ptr, commit_ptr;
    ptr_t total, unissued, free_cnt;
    logic flush_any;

    logic [NrIssuePorts-1:0][TransIdBits-1:0]  wr_idx, iss_idx;
    logic [NrCommitPorts-1:0][TransIdBits-1:0] cmt_idx;
    logic [NrRdPorts-1:0][TransIdBits-1:0]     rd_idx;
    logic [NrRdPorts-1:0][DataWidth-1:0]       rd_data;
    logic [NrIssuePorts-1:0]                   issue_fire, iss_en;
    logic [NrCommitPorts-1:0]                  commit_fire, clr_en;
    logic [NrWbPorts-1:0]                      wb_ok;
    logic [NrEntries-1:0]                      issued, done;
    port_cnt_t                                 n_alloc, n_issue, n_commit;

    // Counts come from registered pointers only: a commit this cycle frees nothing until next.
    assign total     = alloc_ptr - commit_ptr;
    assign unissued  = alloc_ptr - issue_ptr;
    assign free_cnt  = ptr_t'(NrEntries) - total;
    assign flush_any = flush_i | flush_unissued_i;

    for (genvar i = 0; i < NrIssuePorts; i++) begin : g_iss
        assign wr_idx[i]  = TransIdBits'(alloc_ptr + ptr_t'(i));
        assign iss_idx[i] = TransIdBits'(issue_ptr + ptr_t'(i));
        assign iss_en[i]  = port_cnt_t'(i) < n_issue;
        assign issue_data_o[i]     = issue_valid_o[i] ? rd_data[i] : '0;
        assign issue_trans_id_o[i] = issue_valid_o[i] ? iss_idx[i] : '0;
    end

    for (genvar j = 0; j < NrCommitPorts; j++) begin : g_cmt
        assign cmt_idx[j] = TransIdBits'(commit_ptr + ptr_t'(j));
        assign clr_en[j]  = port_cnt_t'(j) < n_commit;
        assign commit_data_o[j]     = commit_valid_o[j] ? rd_data[NrIssuePorts+j] : '0;
        assign commit_trans_id_o[j] = commit_valid_o[j] ? cmt_idx[j] : '0;
    end

    // A write-back is legal only for an issued entry inside [commit_ptr, alloc_ptr).
    for (genvar k = 0; k < NrWbPorts; k++) begin : g_wb
        ptr_t wb_off;
        assign wb_off   = ptr_t'(TransIdBits'(wb_trans_id_i[k] - commit_ptr[TransIdBits-1:0]));
        assign wb_ok[k] = issued[wb_trans_id_i[k]] & (wb_off < total);
        a_wb_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     wb_valid_i[k] |-> wb_ok[k]);
    end

    assign rd_idx = {cmt_idx, iss_idx};

    always_comb begin : p_decode_issue
        logic run;
        run = 1'b1;
        for (int i = 0; i < NrIssuePorts; i++) begin
            run              = run & dec_valid_i[i];
            dec_ack_o[i]     = run & (free_cnt > ptr_t'(i)) & ~flush_any;
            issue_valid_o[i] = (unissued > ptr_t'(i)) & ~stall_i & ~flush_any;
        end
    end

    always_comb begin : p_commit
        logic run;
        run = 1'b1;
        for (int j = 0; j < NrCommitPorts; j++) begin
            run = run & (total > ptr_t'(j)) & issued[cmt_idx[j]] & done[cmt_idx[j]];
            commit_valid_o[j] = run;
        end
    end

    assign issue_fire  = issue_valid_o & issue_ack_i;
    assign commit_fire = commit_valid_o & commit_ack_i;
    assign n_alloc     = lead_ones(MAX_PORTS'(dec_ack_o));
    assign n_issue     = lead_ones(MAX_PORTS'(issue_fire));
    assign n_commit    = lead_ones(MAX_PORTS'(commit_fire));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            commit_ptr <= '0;
        end else if (flush_i) begin
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            commit_ptr <= '0;
        end else begin
            alloc_ptr  <= flush_unissued_i ? issue_ptr : alloc_ptr + ptr_t'(n_alloc);
            issue_ptr  <= issue_ptr + ptr_t'(n_issue);
            commit_ptr <= commit_ptr + ptr_t'(n_commit);
        end
    end

    issue_window_entry_bank #(
        .NrWrPorts (NrIssuePorts),
        .NrRdPorts (NrRdPorts),
        .NrWbPorts (NrWbPorts),
        .NrClrPorts(NrCommitPorts),
        .NrEntries (NrEntries),
        .DataWidth (DataWidth),
        .IdxBits   (TransIdBits)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .wr_en_i   (dec_ack_o),
        .wr_idx_i  (wr_idx),
        .wr_data_i (dec_data_i),
        .iss_en_i  (iss_en),
        .iss_idx_i (iss_idx),
        .done_en_i (wb_valid_i & wb_ok),
        .done_idx_i(wb_trans_id_i),
        .clr_en_i  (clr_en),
        .clr_idx_i (cmt_idx),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .issued_o  (issued),
        .done_o    (done)
    );

    assign occupancy_o = total;
    assign full_o      = (total == ptr_t'(NrEntries));

endmodule

// File: tb/tb_issue_window.sv
// Directed bench for issue_window with hand-computed expectations.
module tb_issue_window;

    localparam int NI = 2, NC = 2, NW = 4, DW = 64, TB = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush, flush_un, stall;
    logic [NI-1:0]         dec_valid, dec_ack, issue_valid, issue_ack;
    logic [NI-1:0][DW-1:0] dec_data, issue_data;
    logic [NI-1:0][TB-1:0] issue_id;
    logic [NW-1:0]         wb_valid;
    logic [NW-1:0][TB-1:0] wb_id;
    logic [NC-1:0]         commit_valid, commit_ack;
    logic [NC-1:0][DW-1:0] commit_data;
    logic [NC-1:0][TB-1:0] commit_id;
    logic [TB:0]           occupancy;
    logic                  full;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_window #(
        .NrIssuePorts(NI), .NrCommitPorts(NC), .NrWbPorts(NW), .NrEntries(8), .DataWidth(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_unissued_i(flush_un),
        .stall_i(stall), .dec_valid_i(dec_valid), .dec_data_i(dec_data), .dec_ack_o(dec_ack),
        .issue_valid_o(issue_valid), .issue_data_o(issue_data), .issue_trans_id_o(issue_id),
        .issue_ack_i(issue_ack), .wb_valid_i(wb_valid), .wb_trans_id_i(wb_id),
        .commit_valid_o(commit_valid), .commit_data_o(commit_data),
        .commit_trans_id_o(commit_id), .commit_ack_i(commit_ack),
        .occupancy_o(occupancy), .full_o(full)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_un = 1'b0; stall = 1'b0;
        dec_valid = '0; dec_data = '0; issue_ack = '0; wb_valid = '0; wb_id = '0;
        commit_ack = '0;
        #12;
        check("rst_occ", 64'(occupancy), 0);
        check("rst_full", 64'(full), 0);
        check("rst_iv", 64'(issue_valid), 0);
        check("rst_cv", 64'(commit_valid), 0);
        check("rst_iid", 64'(issue_id), 0);
        check("rst_idata", issue_data[1], 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-wide decode, then both visible on issue ports
        dec_valid = 2'b11; dec_data[0] = 64'hA; dec_data[1] = 64'hB;
        #1 check("t1_ack", 64'(dec_ack), 2'b11);
        tick();
        dec_valid = '0;
        #1 check("t1_iv", 64'(issue_valid), 2'b11);
        check("t1_iid", 64'(issue_id), {3'd1, 3'd0});
        check("t1_d0", issue_data[0], 64'hA);
        check("t1_d1", issue_data[1], 64'hB);
        check("t1_occ", 64'(occupancy), 2);
        stall = 1'b1;
        #1 check("t1_stall", 64'(issue_valid), 0);
        stall = 1'b0;

        // Gapped ack ignored, then single-port issue
        issue_ack = 2'b10;
        tick();
        check("t3_gap_iv", 64'(issue_valid), 2'b11);
        check("t3_gap_iid", 64'(issue_id), {3'd1, 3'd0});
        issue_ack = 2'b01;
        tick();
        check("t3_one_iv", 64'(issue_valid), 2'b01);
        check("t3_one_iid", 64'(issue_id), 1);
        tick();
        issue_ack = '0;
        #1 check("t3_none", 64'(issue_valid), 0);

        // Out-of-order write-back, in-order commit
        wb_valid = 4'b0001; wb_id[0] = 3'd1;
        tick();
        check("t4_cv_hold", 64'(commit_valid), 0);
        wb_id[0] = 3'd0;
        tick();
        wb_valid = '0;
        #1 check("t4_cv", 64'(commit_valid), 2'b11);
        check("t4_cid", 64'(commit_id), {3'd1, 3'd0});
        check("t4_cd0", commit_data[0], 64'hA);
        check("t4_cd1", commit_data[1], 64'hB);
        commit_ack = 2'b11;
        tick();
        commit_ack = '0;
        #1 check("t4_occ", 64'(occupancy), 0);
        check("t4_cv_after", 64'(commit_valid), 0);

        // Fill the window (pointers start at 2), full blocks decode despite same-cycle commit
        for (int c = 0; c < 4; c++) begin
            dec_valid = 2'b11; dec_data[0] = 64'(16 + 2 * c); dec_data[1] = 64'(17 + 2 * c);
            #1 check("t2_fill_ack", 64'(dec_ack), 2'b11);
            tick();
        end
        dec_valid = '0;
        #1 check("t2_occ", 64'(occupancy), 8);
        check("t2_full", 64'(full), 1);
        for (int c = 0; c < 4; c++) begin
            issue_ack = 2'b11;
            #1 check("t2_iss_iv", 64'(issue_valid), 2'b11);
            tick();
        end
        issue_ack = '0;
        wb_valid = 4'b1111; wb_id = {3'd5, 3'd4, 3'd3, 3'd2};
        tick();
        wb_id = {3'd1, 3'd0, 3'd7, 3'd6};
        tick();
        wb_valid = '0;
        #1 check("t2_cv", 64'(commit_valid), 2'b11);
        check("t2_cid", 64'(commit_id), {3'd3, 3'd2});
        dec_valid = 2'b11; commit_ack = 2'b11;
        #1 check("t2_full_ack", 64'(dec_ack), 0);
        check("t2_full2", 64'(full), 1);
        tick();
        commit_ack = '0;
        #1 check("t2_reack", 64'(dec_ack), 2'b11);
        check("t2_notfull", 64'(full), 0);
        dec_valid = '0;
        #1 check("t2_occ6", 64'(occupancy), 6);
        commit_ack = 2'b11;
        for (int c = 0; c < 3; c++) tick();
        commit_ack = '0;
        #1 check("t2_drain", 64'(occupancy), 0);

        // Flush to zero the pointers; decode and issue suppressed in the flush cycle
        flush = 1'b1; dec_valid = 2'b11;
        #1 check("fl_ack", 64'(dec_ack), 0);
        tick();
        flush = 1'b0; dec_valid = '0;
        #1 check("fl_occ", 64'(occupancy), 0);

        // Wrap: 13 entries one at a time through alloc/issue/wb/commit
        for (int k = 0; k < 13; k++) begin
            dec_valid = 2'b01; dec_data[0] = 64'(256 + k);
            #1 check("t5_ack", 64'(dec_ack), 2'b01);
            tick();
            dec_valid = '0;
            #1 check("t5_iid", 64'(issue_id), 64'(k % 8));
            issue_ack = 2'b01;
            tick();
            issue_ack = '0;
            wb_valid = 4'b0001; wb_id[0] = 3'(k % 8);
            tick();
            wb_valid = '0;
            #1 check("t5_cv", 64'(commit_valid), 2'b01);
            check("t5_cid", 64'(commit_id), 64'(k % 8));
            check("t5_cd", commit_data[0], 64'(256 + k));
            commit_ack = 2'b01;
            tick();
            commit_ack = '0;
        end
        for (int c = 0; c < 4; c++) begin
            dec_valid = 2'b11;
            tick();
        end
        #1 check("t5_occ", 64'(occupancy), 8);
        check("t5_full", 64'(full), 1);
        check("t5_full_ack", 64'(dec_ack), 0);
        dec_valid = '0;
        flush_un = 1'b1;
        tick();
        flush_un = 1'b0;
        #1 check("t5_fu_occ", 64'(occupancy), 0);

        // 3 issued + 2 unissued, drop the unissued ones, issued still commit
        dec_valid = 2'b11;
        tick();
        issue_ack = 2'b11;
        tick();
        dec_valid = 2'b01; issue_ack = 2'b01;
        tick();
        dec_valid = '0; issue_ack = '0;
        #1 check("t6_occ5", 64'(occupancy), 5);
        check("t6_iid", 64'(issue_id), {3'd1, 3'd0});
        flush_un = 1'b1; dec_valid = 2'b11; issue_ack = 2'b11;
        #1 check("t6_fu_ack", 64'(dec_ack), 0);
        check("t6_fu_iv", 64'(issue_valid), 0);
        tick();
        flush_un = 1'b0; dec_valid = '0; issue_ack = '0;
        #1 check("t6_occ3", 64'(occupancy), 3);
        check("t6_iv0", 64'(issue_valid), 0);
        wb_valid = 4'b0111; wb_id = {3'd0, 3'd7, 3'd6, 3'd5};
        tick();
        wb_valid = '0;
        #1 check("t6_cv", 64'(commit_valid), 2'b11);
        check("t6_cid", 64'(commit_id), {3'd6, 3'd5});
        commit_ack = 2'b11;
        tick();
        check("t6_cv2", 64'(commit_valid), 2'b01);
        check("t6_cid2", 64'(commit_id), 7);
        commit_ack = 2'b01;
        tick();
        commit_ack = '0;
        #1 check("t6_occ0", 64'(occupancy), 0);

        // Full flush with committable entries pending
        dec_valid = 2'b11;
        tick();
        dec_valid = '0; issue_ack = 2'b11;
        tick();
        issue_ack = '0; wb_valid = 4'b0011; wb_id = {3'd0, 3'd0, 3'd1, 3'd0};
        tick();
        wb_valid = '0;
        #1 check("t6_pre_cv", 64'(commit_valid), 2'b11);
        flush = 1'b1; dec_valid = 2'b11;
        #1 check("t6_fl_ack", 64'(dec_ack), 0);
        tick();
        flush = 1'b0; dec_valid = '0;
        #1 check("t6_fl_occ", 64'(occupancy), 0);
        check("t6_fl_cv", 64'(commit_valid), 0);
        check("t6_fl_iv", 64'(issue_valid), 0);
        check("t6_fl_full", 64'(full), 0);
        dec_valid = 2'b01;
        tick();
        dec_valid = '0;
        #1 check("t6_post_iid", 64'(issue_id), 0);
        check("t6_post_iv", 64'(issue_valid), 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
